// File: rtl/fft_radix2_stream.sv
// Iterative in-place radix-2 DIT FFT/IFFT over an N-point complex frame, one butterfly per cycle.
// Latency: S*N/2 compute cycles after the last input, then bins stream out in natural order.
// Backpressure: in_ready low outside LOAD; out_data/out_last hold while out_valid && !out_ready.
module fft_radix2_stream #(
  parameter int N     = 8,
  parameter int WIDTH = 32,
  parameter int SCALE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             inverse,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int  HW = WIDTH / 2;     // component width
  localparam int  S  = $clog2(N);     // stage count
  localparam int  SW = $clog2(S);     // stage counter width
  localparam int  JW = S - 1;         // butterfly index / twiddle index width
  localparam int  EW = HW + 3;        // headroom for A +/- W*B before scaling or saturation
  localparam int  PW = 2 * HW + 1;    // full-precision complex product sum
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [EW-1:0] MAXV = EW'((1 << (HW - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  // Elaboration-time cosine/sine via Taylor series; arguments stay within [0, pi).
  function automatic real f_cos(input real x);
    real term, sum;
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i < 30; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real f_sin(input real x);
    real term, sum;
    term = x;
    sum  = x;
    for (int i = 1; i < 30; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Round to nearest Q1.(HW-1) and clip symmetrically so +1.0 never wraps.
  function automatic int tw_quant(input real v);
    real sc;
    int  r, lim;
    lim = (1 << (HW - 1)) - 1;
    sc  = v * real'(lim + 1);
    if (sc >= 0.0) r = $rtoi(sc + 0.5);
    else           r = -$rtoi(0.5 - sc);
    if (r > lim)  r = lim;
    if (r < -lim) r = -lim;
    return r;
  endfunction

  function automatic logic [S-1:0] bitrev(input logic [S-1:0] v);
    logic [S-1:0] r;
    for (int i = 0; i < S; i++) r[i] = v[S-1-i];
    return r;
  endfunction

  // Scale by 2 (floor) or pass through, then clamp into the component range.
  function automatic logic [HW-1:0] fix(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] t;
    t = (SCALE != 0) ? (v >>> 1) : v;
    if (t > MAXV) t = MAXV;
    if (t < MINV) t = MINV;
    return t[HW-1:0];
  endfunction

  logic signed [HW-1:0] cos_tab [N/2];
  logic signed [HW-1:0] sin_tab [N/2];

  for (genvar gk = 0; gk < N / 2; gk++) begin : g_tw
    localparam int C  = tw_quant(f_cos(2.0 * PI * real'(gk) / real'(N)));
    localparam int SN = tw_quant(f_sin(2.0 * PI * real'(gk) / real'(N)));
    assign cos_tab[gk] = HW'(C);
    assign sin_tab[gk] = HW'(SN);
  end

  state_t           state, state_nxt;
  logic [S-1:0]     in_cnt, out_cnt;
  logic [SW-1:0]    stage;
  logic [JW-1:0]    bfly;
  logic             inv_q;
  logic [WIDTH-1:0] mem [N];
  logic             in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  logic [S-1:0]         j_ext, lo_mask, addr_a, addr_b;
  logic [JW-1:0]        tw_k;
  logic [WIDTH-1:0]     word_a, word_b, p_dat, m_dat;
  logic signed [HW-1:0] ar, ai, br, bi, wr, wi;
  logic signed [PW-1:0] prod_r, prod_i;
  logic signed [EW-1:0] wbr, wbi;

  // Butterfly addressing for (stage, bfly) and the in-place butterfly datapath.
  always_comb begin
    j_ext   = {1'b0, bfly};
    lo_mask = (S'(1) << stage) - S'(1);
    addr_a  = (((j_ext >> stage) << stage) << 1) | (j_ext & lo_mask);
    addr_b  = addr_a | (S'(1) << stage);
    tw_k    = JW'((j_ext & lo_mask) << (SW'(S - 1) - stage));
    word_a  = mem[addr_a];
    word_b  = mem[addr_b];
    ar      = word_a[WIDTH-1:HW];
    ai      = word_a[HW-1:0];
    br      = word_b[WIDTH-1:HW];
    bi      = word_b[HW-1:0];
    wr      = cos_tab[tw_k];
    wi      = inv_q ? sin_tab[tw_k] : -sin_tab[tw_k];
    prod_r  = PW'(wr) * PW'(br) - PW'(wi) * PW'(bi);
    prod_i  = PW'(wr) * PW'(bi) + PW'(wi) * PW'(br);
    if (tw_k == '0) begin
      wbr = EW'(br);
      wbi = EW'(bi);
    end else if (tw_k == JW'(N / 4)) begin
      // Quarter-turn: multiply by -j (forward) or +j (inverse) exactly.
      if (inv_q) begin
        wbr = -EW'(bi);
        wbi = EW'(br);
      end else begin
        wbr = EW'(bi);
        wbi = -EW'(br);
      end
    end else begin
      wbr = EW'(prod_r >>> (HW - 1));
      wbi = EW'(prod_i >>> (HW - 1));
    end
    p_dat = {fix(EW'(ar) + wbr), fix(EW'(ai) + wbi)};
    m_dat = {fix(EW'(ar) - wbr), fix(EW'(ai) - wbi)};
  end

  // Frame buffer: bit-reversed writes during LOAD, in-place butterfly writes during COMPUTE.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_fire) begin
      mem[bitrev(in_cnt)] <= in_data;
    end else if (state == COMPUTE) begin
      mem[addr_a] <= p_dat;
      mem[addr_b] <= m_dat;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = !reset;
        if (in_fire && in_cnt == S'(N - 1)) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (stage == SW'(S - 1) && bfly == {JW{1'b1}}) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[out_cnt];
        out_last  = (out_cnt == S'(N - 1));
        if (out_fire && out_cnt == S'(N - 1)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Sample, butterfly, stage and bin counters; all wrap to zero at the end of their phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      stage   <= '0;
      bfly    <= '0;
      inv_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        in_cnt <= in_cnt + S'(1);
        if (in_cnt == '0) inv_q <= inverse;
      end
      if (state == COMPUTE) begin
        bfly <= bfly + JW'(1);
        if (bfly == {JW{1'b1}}) stage <= (stage == SW'(S - 1)) ? '0 : stage + SW'(1);
      end
      if (out_fire) out_cnt <= out_cnt + S'(1);
    end
  end

endmodule

// File: tb/tb_fft_radix2_stream.sv
// Directed bench over three engine configurations: N=4/SCALE=0, N=4/SCALE=1, N=8/SCALE=1.
// Expected bins are hand-derived; latency, hold-under-stall and reset recovery are checked.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_fft_radix2_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        inverse;
  logic        out_ready;
  int          sel;

  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic        ol [3];
  logic        bz [3];
  logic [31:0] od [3];

  assign iv[0] = in_valid && (sel == 0);
  assign iv[1] = in_valid && (sel == 1);
  assign iv[2] = in_valid && (sel == 2);

  fft_radix2_stream #(.N(4), .WIDTH(32), .SCALE(0)) u_n4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[0]), .in_ready(ir[0]),
    .inverse(inverse), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_last(ol[0]), .busy(bz[0]));

  fft_radix2_stream #(.N(4), .WIDTH(32), .SCALE(1)) u_n4s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[1]), .in_ready(ir[1]),
    .inverse(inverse), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_last(ol[1]), .busy(bz[1]));

  fft_radix2_stream #(.N(8), .WIDTH(32), .SCALE(1)) u_n8s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[2]), .in_ready(ir[2]),
    .inverse(inverse), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_last(ol[2]), .busy(bz[2]));

  logic        m_ir, m_ov, m_ol, m_bz;
  logic [31:0] m_od;
  always_comb begin
    m_ir = ir[sel];
    m_ov = ov[sel];
    m_ol = ol[sel];
    m_bz = bz[sel];
    m_od = od[sel];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          total = 0;
  int          bad   = 0;
  int          t_last;
  logic [31:0] stim [8];
  logic [31:0] expv [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed n samples; inverse flips after the first sample to show it is latched per frame.
  task automatic send_frame(input int n, input logic inv, input bit gaps);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = stim[i];
        inverse  = (i == 0) ? inv : ~inv;
      end
      @(negedge clk);
      if (in_valid && m_ir) begin
        t_last = cyc;
        i++;
      end
      step();
    end
    in_valid = 1'b0;
    total++;
    if (i != n) begin
      bad++;
      $display("FAIL send_timeout accepted=%0d required=%0d", i, n);
    end
  endtask

  // Drain n bins against expv, optionally with random out_ready stalls.
  task automatic recv_frame(input int n, input int lat, input bit stall, input string name);
    int          idx, guard;
    bit          first, prev_stall, leak;
    logic [31:0] prev_d;
    logic        prev_l;
    idx = 0; guard = 0; first = 1; prev_stall = 0; leak = 0;
    prev_d = '0; prev_l = 1'b0;
    while (idx < n && guard < 3000) begin
      guard++;
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (m_ir !== 1'b0) leak = 1;
      if (m_ov) begin
        if (first) begin
          first = 0;
          total++;
          if (cyc - t_last != lat) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=%0d", name, cyc - t_last, lat);
          end
        end
        if (prev_stall) begin
          total++;
          if (m_od !== prev_d || m_ol !== prev_l) begin
            bad++;
            $display("FAIL %s_hold bin=%0d got=%h/%b want=%h/%b", name, idx, m_od, m_ol, prev_d, prev_l);
          end
        end
        if (out_ready) begin
          total++;
          if (m_od !== expv[idx] || m_ol !== (idx == n - 1)) begin
            bad++;
            $display("FAIL %s_bin%0d got=%h last=%b want=%h last=%b", name, idx, m_od, m_ol,
                     expv[idx], (idx == n - 1));
          end
          idx++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_d = m_od;
          prev_l = m_ol;
        end
      end
      step();
    end
    out_ready = 1'b0;
    total++;
    if (idx != n) begin
      bad++;
      $display("FAIL %s_timeout bins=%0d want=%0d", name, idx, n);
    end
    total++;
    if (leak) begin
      bad++;
      $display("FAIL %s_in_ready_busy got=1 want=0", name);
    end
    @(negedge clk);
    total++;
    if (m_ir !== 1'b1 || m_bz !== 1'b0) begin
      bad++;
      $display("FAIL %s_reload in_ready=%b busy=%b want 1/0", name, m_ir, m_bz);
    end
    step();
  endtask

  task automatic set4(input logic [31:0] a, b, c, d);
    stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d;
  endtask

  task automatic exp4(input logic [31:0] a, b, c, d);
    expv[0] = a; expv[1] = b; expv[2] = c; expv[3] = d;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    total++;
    if (m_ir !== 1'b1 || m_ov !== 1'b0 || m_bz !== 1'b0 || m_ol !== 1'b0 || m_od !== 32'h0) begin
      bad++;
      $display("FAIL %s in_ready=%b out_valid=%b busy=%b last=%b data=%h want 1/0/0/0/0",
               name, m_ir, m_ov, m_bz, m_ol, m_od);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inverse = 1'b0; in_data = '0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_in_ready dut=%0d got=%b want=0", k, ir[k]);
      end
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || ol[k] !== 1'b0 || bz[k] !== 1'b0 || od[k] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state dut=%0d ir=%b ov=%b ol=%b bz=%b od=%h want 1/0/0/0/0",
                 k, ir[k], ov[k], ol[k], bz[k], od[k]);
      end
    end
    step();
  endtask

  task automatic test_impulse();
    sel = 0;
    set4(32'h1000_0000, 0, 0, 0);
    exp4(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    send_frame(4, 1'b0, 0);
    recv_frame(4, 5, 0, "impulse");
  endtask

  task automatic test_shifted();
    sel = 0;
    set4(0, 32'h1000_0000, 0, 0);
    exp4(32'h1000_0000, 32'h0000_F000, 32'hF000_0000, 32'h0000_1000);
    send_frame(4, 1'b0, 0);
    recv_frame(4, 5, 0, "shift_fwd");
    exp4(32'h1000_0000, 32'h0000_1000, 32'hF000_0000, 32'h0000_F000);
    send_frame(4, 1'b1, 0);
    recv_frame(4, 5, 0, "shift_inv");
  endtask

  task automatic test_dc_sat();
    sel = 0;
    set4(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    exp4(32'h4000_0000, 0, 0, 0);
    send_frame(4, 1'b0, 0);
    recv_frame(4, 5, 0, "dc");
    set4(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    exp4(32'h7FFF_0000, 0, 0, 0);
    send_frame(4, 1'b0, 0);
    recv_frame(4, 5, 0, "sat");
  endtask

  task automatic test_scale();
    sel = 1;
    set4(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    exp4(32'h7FFF_0000, 0, 0, 0);
    send_frame(4, 1'b0, 0);
    recv_frame(4, 5, 0, "scale_dc");
  endtask

  task automatic test_n8_scale();
    sel = 2;
    for (int i = 0; i < 8; i++) begin
      stim[i] = (i == 0) ? 32'h4000_0000 : 32'h0;
      expv[i] = 32'h0800_0000;
    end
    send_frame(8, 1'b0, 0);
    recv_frame(8, 13, 0, "n8_impulse");
    for (int i = 0; i < 8; i++) stim[i] = (i == 1) ? 32'h4000_0000 : 32'h0;
    expv[0] = 32'h0800_0000; expv[1] = 32'h05A8_FA57;
    expv[2] = 32'h0000_F800; expv[3] = 32'hFA57_FA57;
    expv[4] = 32'hF800_0000; expv[5] = 32'hFA58_05A8;
    expv[6] = 32'h0000_0800; expv[7] = 32'h05A8_05A8;
    send_frame(8, 1'b0, 0);
    recv_frame(8, 13, 0, "n8_twiddle");
  endtask

  task automatic test_back_to_back();
    sel = 0;
    set4(0, 32'h1000_0000, 0, 0);
    exp4(32'h1000_0000, 32'h0000_F000, 32'hF000_0000, 32'h0000_1000);
    for (int r = 0; r < 3; r++) begin
      send_frame(4, 1'b0, 1);
      recv_frame(4, 5, 1, "stress_n4");
    end
    sel = 2;
    for (int i = 0; i < 8; i++) stim[i] = (i == 1) ? 32'h4000_0000 : 32'h0;
    expv[0] = 32'h0800_0000; expv[1] = 32'h05A8_FA57;
    expv[2] = 32'h0000_F800; expv[3] = 32'hFA57_FA57;
    expv[4] = 32'hF800_0000; expv[5] = 32'hFA58_05A8;
    expv[6] = 32'h0000_0800; expv[7] = 32'h05A8_05A8;
    send_frame(8, 1'b0, 1);
    recv_frame(8, 13, 1, "stress_n8");
  endtask

  task automatic test_reset_mid();
    bit seen;
    int g;
    sel = 0;
    set4(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    send_frame(4, 1'b0, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("reset_compute");
    set4(32'h1000_0000, 0, 0, 0);
    exp4(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    send_frame(4, 1'b0, 0);
    recv_frame(4, 5, 0, "after_reset_compute");

    set4(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    send_frame(4, 1'b0, 0);
    seen = 0;
    g = 0;
    out_ready = 1'b1;
    while (!seen && g < 50) begin
      g++;
      @(negedge clk);
      if (m_ov) seen = 1;
      step();
    end
    out_ready = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_unload_wait got=no_valid want=valid");
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("reset_unload");
    set4(32'h1000_0000, 0, 0, 0);
    exp4(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    send_frame(4, 1'b0, 0);
    recv_frame(4, 5, 0, "after_reset_unload");
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_shifted();
    test_dc_sat();
    test_scale();
    test_n8_scale();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
